// File: rtl/xnor_term_pkg.sv
// Shared constants and helpers for the xnor_term_pipe block.
package xnor_term_pkg;

    localparam logic MODE_XNOR = 1'b0;
    localparam logic MODE_XOR  = 1'b1;

    // These polarities reproduce the legacy cell: F = ~A&B&C, G = D&~E.
    localparam logic [2:0] F_POL_DEF = 3'b001;
    localparam logic [1:0] G_POL_DEF = 2'b10;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/xnor_term_lane.sv
// One channel: registered polarity-programmable AND terms, then registered XNOR/XOR combine.
module xnor_term_lane
    import xnor_term_pkg::*;
#(
    parameter int WF = 3,
    parameter int WG = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample,
    input  logic          load,
    input  logic [WF-1:0] f,
    input  logic [WG-1:0] g,
    input  logic [WF-1:0] f_pol,
    input  logic [WG-1:0] g_pol,
    input  logic          mode,
    output logic          eq_next,
    output logic          eq
);

    logic f_term;
    logic g_term;

    assign eq_next = (mode == MODE_XOR) ? (f_term ^ g_term) : ~(f_term ^ g_term);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_term <= 1'b0;
            g_term <= 1'b0;
            eq     <= 1'b0;
        end else begin
            if (sample) begin
                f_term <= &(f ^ f_pol);
                g_term <= &(g ^ g_pol);
            end
            if (load) begin
                eq <= eq_next;
            end
        end
    end

endmodule

// File: rtl/xnor_term_pipe.sv
// Multi-channel XNOR-of-product-terms pipeline with run counter and threshold alarm.
// Define XNOR_TERM_STICKY_ALARM_EN to make the alarm latch until reset.
module xnor_term_pipe
    import xnor_term_pkg::*;
#(
    parameter int CH    = 4,
    parameter int WF    = 3,
    parameter int WG    = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CH*WF-1:0] f_in,
    input  logic [CH*WG-1:0] g_in,
    input  logic [WF-1:0]    f_pol,
    input  logic [WG-1:0]    g_pol,
    input  logic             mode,
    input  logic [CNT_W-1:0] thresh,
    output logic             out_valid,
    output logic [CH-1:0]    eq,
    output logic             all_eq,
    output logic [CNT_W-1:0] run_cnt,
    output logic             alarm
);

    logic             v1;
    logic             mode_s;
    logic [CNT_W-1:0] thresh_s;
    logic [CH-1:0]    eq_next;
    logic [CNT_W-1:0] run_cnt_next;
    logic             alarm_hit;
    logic             alarm_next;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        xnor_term_lane #(
            .WF(WF),
            .WG(WG)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .sample  (in_valid),
            .load    (v1),
            .f       (f_in[c*WF +: WF]),
            .g       (g_in[c*WG +: WG]),
            .f_pol   (f_pol),
            .g_pol   (g_pol),
            .mode    (mode_s),
            .eq_next (eq_next[c]),
            .eq      (eq[c])
        );
    end

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        run_cnt_next = run_cnt;
        if (v1) begin
            run_cnt_next = (&eq_next) ? CNT_W'(sat_inc(32'(run_cnt), CNT_W)) : '0;
        end
        alarm_hit = (thresh_s != '0) && (run_cnt_next >= thresh_s);
`ifdef XNOR_TERM_STICKY_ALARM_EN
        alarm_next = alarm | alarm_hit;
`else
        alarm_next = alarm_hit;
`endif
    end

    // Invalid gaps leave the counter untouched, so a run survives idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            mode_s    <= MODE_XNOR;
            thresh_s  <= '0;
            out_valid <= 1'b0;
            all_eq    <= 1'b0;
            run_cnt   <= '0;
            alarm     <= 1'b0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                mode_s   <= mode;
                thresh_s <= thresh;
            end
            if (v1) begin
                all_eq <= &eq_next;
            end
            run_cnt <= run_cnt_next;
            alarm   <= alarm_next;
        end
    end

endmodule
